bus_matrix_rr: RTL and testbench

//  Parametrised shared-bus interconnect: NUM_M masters share one slave-side address/data bus to NUM_S slaves.

---
 rtl/bus_pkg.sv | 46 ++++
 rtl/rr_arbiter.sv | 107 ++++++++++
 rtl/bus_matrix_rr.sv | 110 +++++++++++
 tb/tb_bus_matrix_rr.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bus_pkg
//  Description : Shared definitions for the round-robin bus matrix: arbiter
//                state encoding, page-to-slave decode and a clog2 helper.
//  Revision    : 1.0  initial release
// ============================================================================
package bus_pkg;

    // Arbiter state encoding
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_owned = 1'b1;

    // Slave index width covers the largest supported slave count (16)
    localparam int c_sidx_w = 4;

    typedef struct packed {
        logic                hit;
        logic [c_sidx_w-1:0] idx;
    } dec_t;

    // Ceiling log2, at least 0; usable in constant expressions
    function automatic int clog2_f(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Map a page number to a slave index; hit only for base <= page < base+num
    function automatic dec_t decode_page(input logic [31:0] page, input int base, input int num);
        dec_t        d;
        logic [31:0] off;
        off   = page - 32'(base);
        d.hit = (page >= 32'(base)) && (off < 32'(num));
        d.idx = d.hit ? off[c_sidx_w-1:0] : '0;
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Round-robin bus arbiter with bus lock and optional hold-time
//                preemption. Grant is derived from registered state only.
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_M    = 4,
    parameter int MAX_HOLD = 0
)
(
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_M-1:0]             req,
    output logic [NUM_M-1:0]             grant,
    output logic                         owned,
    output logic [clog2_f(NUM_M)-1:0]    owner
);

    localparam int IW  = clog2_f(NUM_M);
    localparam int IW1 = IW + 1;
    localparam int HW  = clog2_f(MAX_HOLD + 2);
    localparam logic [HW-1:0] c_hold_max  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] c_hold_init = (MAX_HOLD > 0) ? HW'(1) : HW'(0);

    logic [0:0]       r_state;
    logic [IW-1:0]    r_owner;
    logic [IW-1:0]    r_ptr;
    logic [HW-1:0]    r_hold;

    logic [NUM_M-1:0] w_owner_oh;
    logic [NUM_M-1:0] w_others;
    logic [IW-1:0]    w_owner_nxt;
    logic [IW:0]      w_idle_pick;
    logic [IW:0]      w_rot_pick;
    logic             w_release;
    logic             w_preempt;

    // First set bit of vec searching upward from start, wrapping; MSB = found
    function automatic logic [IW:0] find_next(input logic [NUM_M-1:0] vec, input logic [IW-1:0] start);
        logic [IW:0] pos;
        logic [IW:0] pick;
        pick = '0;
        for (int i = 0; i < NUM_M; i++) begin
            pos = {1'b0, start} + IW1'(i);
            if (pos >= IW1'(NUM_M)) begin
                pos = pos - IW1'(NUM_M);
            end
            if (!pick[IW] && vec[pos[IW-1:0]]) begin
                pick = {1'b1, pos[IW-1:0]};
            end
        end
        return pick;
    endfunction

    assign w_owner_oh  = NUM_M'(1) << r_owner;
    assign w_others    = req & ~w_owner_oh;
    assign w_owner_nxt = (r_owner == IW'(NUM_M - 1)) ? '0 : r_owner + 1'b1;
    assign w_idle_pick = find_next(req, r_ptr);
    // Preempted owner is excluded so it re-enters the rotation last
    assign w_rot_pick  = find_next(w_others, w_owner_nxt);
    assign w_release   = ~req[r_owner];
    assign w_preempt   = (MAX_HOLD > 0) && (r_hold == c_hold_max) && (|w_others);

    assign owned = (r_state == c_st_owned);
    assign owner = r_owner;
    assign grant = owned ? w_owner_oh : '0;

    // Ownership, rotation pointer and hold counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_st_idle;
            r_owner <= '0;
            r_ptr   <= '0;
            r_hold  <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (w_idle_pick[IW]) begin
                        r_state <= c_st_owned;
                        r_owner <= w_idle_pick[IW-1:0];
                        r_hold  <= c_hold_init;
                    end
                end
                default: begin
                    if (w_release || w_preempt) begin
                        r_ptr <= w_owner_nxt;
                        if (w_rot_pick[IW]) begin
                            r_owner <= w_rot_pick[IW-1:0];
                            r_hold  <= c_hold_init;
                        end else begin
                            r_state <= c_st_idle;
                            r_hold  <= '0;
                        end
                    end else if (r_hold < c_hold_max) begin
                        r_hold <= r_hold + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_matrix_rr.sv
`default_nettype none
// ============================================================================
//  Module      : bus_matrix_rr
//  Description : Shared-bus interconnect, NUM_M masters to NUM_S slaves with
//                round-robin arbitration, page decode and one-cycle read return.
//  Revision    : 1.0  initial release
// ============================================================================
module bus_matrix_rr
    import bus_pkg::*;
#(
    parameter int NUM_M     = 4,
    parameter int NUM_S     = 8,
    parameter int AW        = 16,
    parameter int DW        = 32,
    parameter int PAGE_LSB  = 8,
    parameter int BASE_PAGE = 0,
    parameter int MAX_HOLD  = 0
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_M-1:0]      m_req,
    input  logic [NUM_M-1:0]      m_wr,
    input  logic [NUM_M*AW-1:0]   m_addr,
    input  logic [NUM_M*DW-1:0]   m_dout,
    output logic [NUM_M-1:0]      m_grant,
    output logic [DW-1:0]         m_din,
    output logic [NUM_S-1:0]      s_sel,
    output logic                  s_wr,
    output logic [AW-1:0]         s_addr,
    output logic [DW-1:0]         s_din,
    input  logic [NUM_S*DW-1:0]   s_dout,
    output logic                  dec_err
);

    localparam int IW = clog2_f(NUM_M);

    logic                w_owned;
    logic [IW-1:0]       w_owner;
    logic [AW-1:0]       w_own_addr;
    logic [DW-1:0]       w_own_dout;
    logic                w_own_wr;
    dec_t                w_dec;
    logic                w_hit;

    logic                r_rd_valid;
    logic [c_sidx_w-1:0] r_rd_idx;
    logic                r_dec_err;

    rr_arbiter #(
        .NUM_M    (NUM_M),
        .MAX_HOLD (MAX_HOLD)
    ) u_arb (
        .clk   (clk),
        .reset (reset),
        .req   (m_req),
        .grant (m_grant),
        .owned (w_owned),
        .owner (w_owner)
    );

    // Select the current owner's address, write data and write strobe
    always_comb begin
        w_own_addr = '0;
        w_own_dout = '0;
        w_own_wr   = 1'b0;
        for (int i = 0; i < NUM_M; i++) begin
            if (w_owner == IW'(i)) begin
                w_own_addr = m_addr[i*AW +: AW];
                w_own_dout = m_dout[i*DW +: DW];
                w_own_wr   = m_wr[i];
            end
        end
    end

    assign w_dec  = decode_page(32'(w_own_addr[AW-1:PAGE_LSB]), BASE_PAGE, NUM_S);
    assign w_hit  = w_owned & w_dec.hit;

    assign s_sel  = w_hit ? (NUM_S'(1) << w_dec.idx) : '0;
    assign s_wr   = w_owned & w_own_wr;
    assign s_addr = w_owned ? w_own_addr : '0;
    assign s_din  = w_owned ? w_own_dout : '0;

    // Remember which slave was accessed so its data can be returned next cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_idx   <= '0;
            r_dec_err  <= 1'b0;
        end else begin
            r_rd_valid <= w_hit;
            r_rd_idx   <= w_dec.idx;
            r_dec_err  <= w_owned & ~w_dec.hit;
        end
    end

    // Return the previously selected slave's data, zero when nothing was selected
    always_comb begin
        m_din = '0;
        for (int k = 0; k < NUM_S; k++) begin
            if (r_rd_valid && (r_rd_idx == c_sidx_w'(k))) begin
                m_din = s_dout[k*DW +: DW];
            end
        end
    end

    assign dec_err = r_dec_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_matrix_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_matrix_rr
//  Description : Self-checking bench for bus_matrix_rr with synchronous ram
//                slave models and a read-data scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_bus_matrix_rr;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    m_req = '0;
    logic [3:0]    m_wr = '0;
    logic [63:0]   m_addr = '0;
    logic [127:0]  m_dout = '0;
    logic [3:0]    m_grant;
    logic [31:0]   m_din;
    logic [7:0]    s_sel;
    logic          s_wr;
    logic [15:0]   s_addr;
    logic [31:0]   s_din;
    logic [255:0]  s_dout;
    logic          dec_err;

    logic [3:0]    b_grant;
    logic [31:0]   b_din;
    logic [7:0]    b_sel;
    logic          b_wr;
    logic [15:0]   b_addr;
    logic [31:0]   b_sdin;
    logic          b_err;
    logic [255:0]  b_sdout = '0;

    typedef struct {
        int          due;
        logic [31:0] data;
        string       tag;
    } exp_t;

    exp_t        sb_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc_cnt = 0;
    logic [31:0] ref_mem [8][256];
    logic [31:0] ram [8][256];
    logic [31:0] ram_q [8];

    always #5 clk = ~clk;

    bus_matrix_rr #(.MAX_HOLD(4)) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .m_dout(m_dout), .m_grant(m_grant), .m_din(m_din), .s_sel(s_sel),
        .s_wr(s_wr), .s_addr(s_addr), .s_din(s_din), .s_dout(s_dout), .dec_err(dec_err)
    );

    bus_matrix_rr #(.MAX_HOLD(0)) dut0 (
        .clk(clk), .reset(reset), .m_req(m_req), .m_wr(m_wr), .m_addr(m_addr),
        .m_dout(m_dout), .m_grant(b_grant), .m_din(b_din), .s_sel(b_sel),
        .s_wr(b_wr), .s_addr(b_addr), .s_din(b_sdin), .s_dout(b_sdout), .dec_err(b_err)
    );

    // Synchronous ram slaves: registered read data one cycle after select
    always @(posedge clk) begin
        for (int k = 0; k < 8; k++) begin
            if (s_sel[k]) begin
                if (s_wr) ram[k][s_addr[7:0]] <= s_din;
                ram_q[k] <= ram[k][s_addr[7:0]];
            end
        end
    end

    always_comb begin
        s_dout = '0;
        for (int k = 0; k < 8; k++) s_dout[k*32 +: 32] = ram_q[k];
    end

    // One clock; then pop and compare every read result due this cycle
    task automatic advance();
        exp_t e;
        @(posedge clk);
        cyc_cnt++;
        @(negedge clk);
        while (sb_q.size() > 0 && sb_q[0].due <= cyc_cnt) begin
            e = sb_q.pop_front();
            total++;
            if (e.due != cyc_cnt) begin
                bad++;
                $display("FAIL %s: read result due cycle %0d not seen (now %0d)", e.tag, e.due, cyc_cnt);
            end else if (m_din !== e.data) begin
                bad++;
                $display("FAIL %s: m_din=%h required %h (cycle %0d)", e.tag, m_din, e.data, cyc_cnt);
            end
        end
    endtask

    task automatic set_master(input int i, input logic rq, input logic wr, input logic [15:0] a, input logic [31:0] d);
        m_req[i]           = rq;
        m_wr[i]            = wr;
        m_addr[i*16 +: 16] = a;
        m_dout[i*32 +: 32] = d;
    endtask

    // Owned read of address a this cycle: data expected on m_din next cycle
    task automatic expect_read(input string tag, input logic [15:0] a);
        exp_t e;
        e.due  = cyc_cnt + 1;
        e.data = ref_mem[a[10:8]][a[7:0]];
        e.tag  = tag;
        sb_q.push_back(e);
    endtask

    task automatic do_reset();
        m_req = '0;
        reset = 1'b1;
        advance();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        advance(); advance(); advance();
        reset = 1'b0;
        total++;
        if ({m_grant, s_sel, s_wr, s_addr, s_din, m_din, dec_err} !== '0) begin
            bad++;
            $display("FAIL reset_init: grant=%b sel=%b wr=%b addr=%h din=%h mdin=%h err=%b required all zero",
                     m_grant, s_sel, s_wr, s_addr, s_din, m_din, dec_err);
        end
        total++;
        if ({b_grant, b_sel, b_wr, b_addr, b_sdin, b_din, b_err} !== '0) begin
            bad++;
            $display("FAIL reset_init_nohold: outputs=%h required 0", {b_grant, b_sel, b_wr, b_addr, b_sdin, b_din, b_err});
        end
        set_master(0, 1'b1, 1'b0, 16'h0100, 32'h0);
        advance();
        total++;
        if (m_grant !== 4'b0001) begin
            bad++;
            $display("FAIL reset_pre_grant: grant=%b required 0001", m_grant);
        end
        advance();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            advance();
            total++;
            if (m_grant !== 4'b0000 || s_sel !== 8'h00 || m_din !== 32'h0 || dec_err !== 1'b0 ||
                s_wr !== 1'b0 || s_addr !== 16'h0 || s_din !== 32'h0) begin
                bad++;
                $display("FAIL reset_mid_grant: grant=%b sel=%b mdin=%h err=%b wr=%b addr=%h required zeros",
                         m_grant, s_sel, m_din, dec_err, s_wr, s_addr);
            end
        end
        m_req = '0;
        reset = 1'b0;
        advance();
    endtask

    task automatic test_single();
        set_master(1, 1'b1, 1'b0, 16'h0205, 32'h0);
        #1;
        total++;
        if (m_grant !== 4'b0000) begin
            bad++;
            $display("FAIL single_idle: grant=%b required 0000", m_grant);
        end
        advance();
        total++;
        if (m_grant !== 4'b0010 || s_sel !== 8'h04 || s_addr !== 16'h0205) begin
            bad++;
            $display("FAIL single_grant: grant=%b sel=%b addr=%h required 0010 00000100 0205", m_grant, s_sel, s_addr);
        end
        expect_read("single_read", 16'h0205);
        m_req = '0;
        advance();
        advance();
        advance();
        total++;
        if (m_grant !== 4'b0000 || m_din !== 32'h0) begin
            bad++;
            $display("FAIL single_release: grant=%b mdin=%h required 0000 0", m_grant, m_din);
        end
    endtask

    task automatic test_round_robin();
        int          order[4] = '{0, 1, 3, 0};
        logic [15:0] addr[4]  = '{16'h0110, 16'h0221, 16'h0000, 16'h0433};
        int          prev = -1;
        logic [3:0]  exp_g;
        do_reset();
        set_master(0, 1'b1, 1'b0, addr[0], 32'h0);
        set_master(1, 1'b1, 1'b0, addr[1], 32'h0);
        set_master(3, 1'b1, 1'b0, addr[3], 32'h0);
        advance();
        for (int p = 0; p < 4; p++) begin
            for (int h = 0; h < 3; h++) begin
                exp_g = 4'(1 << order[p]);
                total++;
                if (m_grant !== exp_g) begin
                    bad++;
                    $display("FAIL rr_grant: phase %0d cycle %0d grant=%b required %b", p, h, m_grant, exp_g);
                end
                if (h == 0 && prev >= 0) m_req[prev] = 1'b1;
                expect_read("rr_read", addr[order[p]]);
                if (h == 2) m_req[order[p]] = 1'b0;
                advance();
            end
            prev = order[p];
        end
        m_req = '0;
        advance();
        advance();
    endtask

    task automatic test_preempt();
        logic [3:0] exp_g;
        do_reset();
        set_master(0, 1'b1, 1'b0, 16'h0110, 32'h0);
        set_master(2, 1'b0, 1'b0, 16'h0300, 32'h0);
        advance();
        for (int k = 1; k <= 14; k++) begin
            if (k == 2) m_req[2] = 1'b1;
            exp_g = (k >= 5 && k <= 7) ? 4'b0100 : 4'b0001;
            total++;
            if (m_grant !== exp_g) begin
                bad++;
                $display("FAIL preempt_grant: cycle %0d grant=%b required %b", k, m_grant, exp_g);
            end
            if (k <= 8) begin
                total++;
                if (b_grant !== 4'b0001) begin
                    bad++;
                    $display("FAIL nohold_grant: cycle %0d grant=%b required 0001", k, b_grant);
                end
            end
            if (k == 7) m_req[2] = 1'b0;
            advance();
        end
        m_req = '0;
        advance();
        total++;
        if (m_grant !== 4'b0000 || b_grant !== 4'b0000) begin
            bad++;
            $display("FAIL preempt_idle: grant=%b nohold=%b required 0000", m_grant, b_grant);
        end
    endtask

    task automatic test_decode_miss();
        set_master(1, 1'b1, 1'b0, 16'h0F00, 32'h0);
        advance();
        total++;
        if (m_grant !== 4'b0010 || s_sel !== 8'h00 || dec_err !== 1'b0) begin
            bad++;
            $display("FAIL miss_sel: grant=%b sel=%b err=%b required 0010 0 0", m_grant, s_sel, dec_err);
        end
        advance();
        total++;
        if (dec_err !== 1'b1 || m_din !== 32'h0) begin
            bad++;
            $display("FAIL miss_err: err=%b mdin=%h required 1 0", dec_err, m_din);
        end
        m_addr[16 +: 16] = 16'h07FF;
        #1;
        total++;
        if (s_sel !== 8'h80 || s_addr !== 16'h07FF) begin
            bad++;
            $display("FAIL last_page_sel: sel=%b addr=%h required 10000000 07FF", s_sel, s_addr);
        end
        expect_read("last_page_read", 16'h07FF);
        advance();
        total++;
        if (dec_err !== 1'b0) begin
            bad++;
            $display("FAIL miss_err_clear: err=%b required 0", dec_err);
        end
        m_req = '0;
        advance();
        advance();
    endtask

    task automatic test_write_read();
        set_master(3, 1'b1, 1'b1, 16'h0310, 32'h12345678);
        advance();
        total++;
        if (m_grant !== 4'b1000 || s_wr !== 1'b1 || s_din !== 32'h12345678 || s_sel !== 8'h08) begin
            bad++;
            $display("FAIL write_cycle: grant=%b wr=%b din=%h sel=%b required 1000 1 12345678 00001000",
                     m_grant, s_wr, s_din, s_sel);
        end
        ref_mem[3][8'h10] = 32'h12345678;
        advance();
        m_wr[3] = 1'b0;
        #1;
        total++;
        if (s_wr !== 1'b0) begin
            bad++;
            $display("FAIL read_cycle_wr: wr=%b required 0", s_wr);
        end
        expect_read("write_then_read", 16'h0310);
        advance();
        m_req = '0;
        advance();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            for (int a = 0; a < 256; a++) begin
                ref_mem[k][a] = 32'hA500_0000 | 32'(k << 12) | 32'(a);
                ram[k][a]     = ref_mem[k][a];
            end
        end
        ref_mem[2][5] = 32'hDEADBEEF;
        ram[2][5]     = 32'hDEADBEEF;

        test_reset();
        test_single();
        test_round_robin();
        test_preempt();
        test_decode_miss();
        test_write_read();

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain: %0d reads pending required 0", sb_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
